// File: rtl/ddr2_rd_data_checker.sv
// DDR2 read-data checker.
// Compares every accepted read beat against a deterministic byte pattern
// (index + seed, replicated on the rising half, inverted on the falling
// half), tracks how many beats are still owed by issued read commands and
// runs a watchdog on beats that never arrive. All error status is sticky
// until clear or reset.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | calibration not done; read commands and beats are ignored
// RUN   | checking beats, no error seen since the last clear/reset
// FAIL  | mismatch, timeout or unexpected beat seen; still checking
module ddr2_rd_data_checker #(
    parameter int          DQ_WIDTH     = 72,
    parameter int          TIMEOUT      = 1024,
    parameter logic [7:0]  PATTERN_SEED = 8'h00
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    init_done,
    input  logic                    clear,
    input  logic                    rd_req,
    input  logic [2:0]              burst_length_div2,
    input  logic                    read_data_valid,
    input  logic [2*DQ_WIDTH-1:0]   read_data_fifo_out,
    output logic                    error,
    output logic                    error_pulse,
    output logic [15:0]             error_count,
    output logic [31:0]             beats_checked,
    output logic [2*DQ_WIDTH-1:0]   first_err_data,
    output logic [7:0]              first_err_beat,
    output logic [7:0]              outstanding,
    output logic                    timeout_err,
    output logic                    unexpected_err
);

    localparam int BYTES = DQ_WIDTH / 8;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FAIL = 2'd2
    } state_t;

    state_t                  r_state;
    logic [7:0]              r_exp_idx;
    logic                    r_pipe_vld;
    logic [2*DQ_WIDTH-1:0]   r_pipe_data;
    logic [7:0]              r_pipe_idx;
    logic [7:0]              r_outstanding;
    logic [WD_W-1:0]         r_wd_cnt;
    logic                    r_mismatch_seen;
    logic                    r_timeout_err;
    logic                    r_unexp_err;
    logic                    r_err_pulse;
    logic [15:0]             r_err_cnt;
    logic [31:0]             r_beats;
    logic [2*DQ_WIDTH-1:0]   r_first_data;
    logic [7:0]              r_first_beat;

    logic                    w_active;
    logic                    w_beat_acc;
    logic                    w_req_acc;
    logic [7:0]              w_exp_byte;
    logic [DQ_WIDTH-1:0]     w_exp_rise;
    logic [2*DQ_WIDTH-1:0]   w_exp_beat;
    logic                    w_mismatch;
    logic                    w_unexp;
    logic [2:0]              w_add;
    logic                    w_sub;
    logic [8:0]              w_out_sum;
    logic [7:0]              w_out_next;
    logic                    w_wd_run;
    logic                    w_wd_expire;
    logic                    w_fail_evt;

    // clear wins over everything, so a same-cycle beat or command is dropped
    assign w_active   = (r_state != ST_IDLE);
    assign w_beat_acc = read_data_valid && w_active && !clear;
    assign w_req_acc  = rd_req && w_active && !clear;

    // the registered beat is compared against the pattern of the index it was accepted at
    assign w_exp_byte = r_pipe_idx + PATTERN_SEED;
    assign w_exp_rise = {BYTES{w_exp_byte}};
    assign w_exp_beat = {~w_exp_rise, w_exp_rise};
    assign w_mismatch = r_pipe_vld && (r_pipe_data != w_exp_beat);

    // a beat with nothing owed is flagged but does not drive the count negative
    assign w_unexp    = w_beat_acc && (r_outstanding == 8'd0);
    assign w_add      = w_req_acc ? burst_length_div2 : 3'd0;
    assign w_sub      = w_beat_acc && !w_unexp;
    assign w_out_sum  = {1'b0, r_outstanding} + {6'd0, w_add} - {8'd0, w_sub};
    assign w_out_next = w_out_sum[8] ? 8'hFF : w_out_sum[7:0];

    // watchdog only ticks while beats are owed and none shows up
    assign w_wd_run    = w_active && !clear && (r_outstanding != 8'd0) &&
                         !w_beat_acc && !r_timeout_err;
    assign w_wd_expire = w_wd_run && (r_wd_cnt == WD_W'(TIMEOUT - 1));

    assign w_fail_evt  = !clear && (w_mismatch || w_wd_expire || w_unexp);

    // sequencing state: losing calibration always returns to IDLE with status kept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else if (!init_done) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_RUN;
                ST_RUN:  if (w_fail_evt) r_state <= ST_FAIL;
                ST_FAIL: if (clear) r_state <= ST_RUN;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // one-stage beat pipeline and expected-index counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pipe_vld  <= 1'b0;
            r_pipe_data <= '0;
            r_pipe_idx  <= 8'd0;
            r_exp_idx   <= 8'd0;
        end else if (clear) begin
            r_pipe_vld  <= 1'b0;
            r_pipe_data <= '0;
            r_pipe_idx  <= 8'd0;
            r_exp_idx   <= 8'd0;
        end else begin
            r_pipe_vld <= w_beat_acc;
            if (w_beat_acc) begin
                r_pipe_data <= read_data_fifo_out;
                r_pipe_idx  <= r_exp_idx;
                r_exp_idx   <= r_exp_idx + 8'd1;
            end
        end
    end

    // compare results: counters, strobe and first-mismatch capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_pulse     <= 1'b0;
            r_err_cnt       <= 16'd0;
            r_beats         <= 32'd0;
            r_mismatch_seen <= 1'b0;
            r_first_data    <= '0;
            r_first_beat    <= 8'd0;
            r_unexp_err     <= 1'b0;
        end else if (clear) begin
            r_err_pulse     <= 1'b0;
            r_err_cnt       <= 16'd0;
            r_beats         <= 32'd0;
            r_mismatch_seen <= 1'b0;
            r_first_data    <= '0;
            r_first_beat    <= 8'd0;
            r_unexp_err     <= 1'b0;
        end else begin
            r_err_pulse <= w_mismatch;
            if (r_pipe_vld) begin
                r_beats <= r_beats + 32'd1;
            end
            if (w_mismatch) begin
                if (r_err_cnt != 16'hFFFF) begin
                    r_err_cnt <= r_err_cnt + 16'd1;
                end
                if (!r_mismatch_seen) begin
                    r_first_data <= r_pipe_data;
                    r_first_beat <= r_pipe_idx;
                end
                r_mismatch_seen <= 1'b1;
            end
            if (w_unexp) begin
                r_unexp_err <= 1'b1;
            end
        end
    end

    // outstanding-beat tracker and read-data watchdog
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_outstanding <= 8'd0;
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else if (clear) begin
            r_outstanding <= 8'd0;
            r_wd_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_outstanding <= w_out_next;
            if (w_wd_expire) begin
                r_wd_cnt      <= WD_W'(TIMEOUT);
                r_timeout_err <= 1'b1;
            end else if (w_wd_run) begin
                r_wd_cnt <= r_wd_cnt + WD_W'(1);
            end else if (!r_timeout_err) begin
                r_wd_cnt <= '0;
            end
        end
    end

    assign error          = r_mismatch_seen | r_timeout_err | r_unexp_err;
    assign error_pulse    = r_err_pulse;
    assign error_count    = r_err_cnt;
    assign beats_checked  = r_beats;
    assign first_err_data = r_first_data;
    assign first_err_beat = r_first_beat;
    assign outstanding    = r_outstanding;
    assign timeout_err    = r_timeout_err;
    assign unexpected_err = r_unexp_err;

endmodule

// File: tb/tb_ddr2_rd_data_checker.sv
// Bench for ddr2_rd_data_checker with DQ_WIDTH=8, TIMEOUT=16, seed 0.
module tb_ddr2_rd_data_checker;

    localparam int DQ = 8;
    localparam int TO = 16;
    localparam int W  = 2 * DQ;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FAIL = 2'd2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          init_done;
    logic          clear;
    logic          rd_req;
    logic [2:0]    bl;
    logic          rdv;
    logic [W-1:0]  rdata;
    logic          error;
    logic          error_pulse;
    logic [15:0]   error_count;
    logic [31:0]   beats_checked;
    logic [W-1:0]  first_err_data;
    logic [7:0]    first_err_beat;
    logic [7:0]    outstanding;
    logic          timeout_err;
    logic          unexpected_err;

    ddr2_rd_data_checker #(
        .DQ_WIDTH     (DQ),
        .TIMEOUT      (TO),
        .PATTERN_SEED (8'h00)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .init_done          (init_done),
        .clear              (clear),
        .rd_req             (rd_req),
        .burst_length_div2  (bl),
        .read_data_valid    (rdv),
        .read_data_fifo_out (rdata),
        .error              (error),
        .error_pulse        (error_pulse),
        .error_count        (error_count),
        .beats_checked      (beats_checked),
        .first_err_data     (first_err_data),
        .first_err_beat     (first_err_beat),
        .outstanding        (outstanding),
        .timeout_err        (timeout_err),
        .unexpected_err     (unexpected_err)
    );

    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_total = 0;
    bit          sb_q[$];
    logic [31:0] prev_bc = 32'd0;
    logic [7:0]  m_idx = 8'd0;

    typedef struct {
        bit         rq;
        logic [2:0] len;
        bit         v;
        logic [7:0] exp_out;
        bit         exp_unexp;
    } vec_t;
    vec_t vecs[13];

    function automatic logic [W-1:0] pat(input logic [7:0] idx);
        logic [DQ-1:0] rise;
        rise = {(DQ/8){idx}};
        return {~rise, rise};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // one clock: drive inputs, take the edge, record accepted beats in the scoreboard
    task automatic step(input bit rq, input logic [2:0] len, input bit v,
                        input logic [W-1:0] d, input bit acc);
        rd_req = rq; bl = len; rdv = v; rdata = d;
        @(posedge clk);
        if (v && acc) begin
            sb_q.push_back(d !== pat(m_idx));
            m_idx = m_idx + 8'd1;
        end
        #1;
        rd_req = 1'b0; bl = 3'd0; rdv = 1'b0; rdata = '0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 3'd0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        sb_q.delete();
        m_idx = 8'd0;
        prev_bc = 32'd0;
    endtask

    // scoreboard consumer: each time a beat gets counted, its strobe must match
    always @(negedge clk) begin
        if (beats_checked !== prev_bc) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_count", beats_checked, prev_bc);
            end else begin
                chk("sb_pulse", error_pulse, sb_q.pop_front());
                chk("sb_count_step", beats_checked, prev_bc + 32'd1);
            end
            prev_bc = beats_checked;
        end
    end

    logic pulse_at[6];

    initial begin
        vecs[0]  = '{1'b1, 3'd4, 1'b0, 8'd4, 1'b0};
        vecs[1]  = '{1'b0, 3'd0, 1'b1, 8'd3, 1'b0};
        vecs[2]  = '{1'b0, 3'd0, 1'b1, 8'd2, 1'b0};
        vecs[3]  = '{1'b0, 3'd0, 1'b1, 8'd1, 1'b0};
        vecs[4]  = '{1'b0, 3'd0, 1'b1, 8'd0, 1'b0};
        vecs[5]  = '{1'b1, 3'd3, 1'b0, 8'd3, 1'b0};
        vecs[6]  = '{1'b1, 3'd0, 1'b0, 8'd3, 1'b0};
        vecs[7]  = '{1'b1, 3'd1, 1'b1, 8'd3, 1'b0};
        vecs[8]  = '{1'b1, 3'd2, 1'b1, 8'd4, 1'b0};
        vecs[9]  = '{1'b0, 3'd0, 1'b1, 8'd3, 1'b0};
        vecs[10] = '{1'b0, 3'd0, 1'b1, 8'd2, 1'b0};
        vecs[11] = '{1'b0, 3'd0, 1'b1, 8'd1, 1'b0};
        vecs[12] = '{1'b0, 3'd0, 1'b1, 8'd0, 1'b0};

        reset_n = 1'b0; init_done = 1'b0; clear = 1'b0;
        rd_req = 1'b0; bl = 3'd0; rdv = 1'b0; rdata = '0;
        #3;
        chk("rst_error", error, 0);
        chk("rst_pulse", error_pulse, 0);
        chk("rst_err_cnt", error_count, 0);
        chk("rst_beats", beats_checked, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_first_data", first_err_data, 0);
        chk("rst_state", dut.r_state, S_IDLE);
        @(negedge clk);
        reset_n = 1'b1;

        // IDLE ignores commands and beats
        step(1'b1, 3'd4, 1'b1, pat(8'd0), 1'b0);
        idle(2);
        chk("idle_outstanding", outstanding, 0);
        chk("idle_beats", beats_checked, 0);
        chk("idle_unexp", unexpected_err, 0);

        init_done = 1'b1;
        idle(1);
        chk("run_state", dut.r_state, S_RUN);

        // table: outstanding accounting with clean data
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].rq, vecs[i].len, vecs[i].v, pat(m_idx), vecs[i].v);
            chk($sformatf("vec%0d_outstanding", i), outstanding, vecs[i].exp_out);
            chk($sformatf("vec%0d_unexp", i), unexpected_err, vecs[i].exp_unexp);
        end
        idle(2);
        chk("tbl_beats", beats_checked, 10);
        chk("tbl_error", error, 0);
        chk("tbl_sb_drained", sb_q.size(), 0);

        // mismatch on beat 2: strobe timing and first-error capture
        do_clear();
        step(1'b1, 3'd4, 1'b0, '0, 1'b0);
        for (int b = 0; b < 4; b++) begin
            step(1'b0, 3'd0, 1'b1, (b == 2) ? 16'h0000 : pat(m_idx), 1'b1);
            pulse_at[b] = error_pulse;
        end
        idle(1); pulse_at[4] = error_pulse;
        idle(1); pulse_at[5] = error_pulse;
        chk("mm_pulse_e2", pulse_at[2], 0);
        chk("mm_pulse_e3", pulse_at[3], 1);
        chk("mm_pulse_e4", pulse_at[4], 0);
        chk("mm_err_cnt", error_count, 1);
        chk("mm_first_beat", first_err_beat, 2);
        chk("mm_first_data", first_err_data, 16'h0000);
        chk("mm_error", error, 1);
        chk("mm_beats", beats_checked, 4);
        chk("mm_state", dut.r_state, S_FAIL);

        // a second mismatch counts but leaves the capture alone
        step(1'b1, 3'd1, 1'b0, '0, 1'b0);
        step(1'b0, 3'd0, 1'b1, 16'h1234, 1'b1);
        idle(2);
        chk("mm2_err_cnt", error_count, 2);
        chk("mm2_first_beat", first_err_beat, 2);
        chk("mm2_first_data", first_err_data, 16'h0000);
        chk("mm2_beats", beats_checked, 5);

        do_clear();
        chk("clr_state", dut.r_state, S_RUN);
        chk("clr_error", error, 0);
        chk("clr_err_cnt", error_count, 0);
        chk("clr_first_beat", first_err_beat, 0);
        chk("clr_beats", beats_checked, 0);

        // watchdog: len 2 and no data
        step(1'b1, 3'd2, 1'b0, '0, 1'b0);
        idle(15);
        chk("to_before", timeout_err, 0);
        idle(1);
        chk("to_at_limit", timeout_err, 1);
        chk("to_error", error, 1);
        chk("to_state", dut.r_state, S_FAIL);
        do_clear();
        chk("to_clr_flag", timeout_err, 0);
        chk("to_clr_outstanding", outstanding, 0);
        chk("to_clr_error", error, 0);
        chk("to_clr_state", dut.r_state, S_RUN);

        // beat with nothing owed
        step(1'b0, 3'd0, 1'b1, pat(m_idx), 1'b1);
        chk("ux_flag", unexpected_err, 1);
        chk("ux_outstanding", outstanding, 0);
        idle(1);
        chk("ux_beats", beats_checked, 1);
        chk("ux_error", error, 1);
        do_clear();

        // 256 beats wrap the index; beat 257 must be FF00 again
        step(1'b1, 3'd1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 256; i++) step(1'b1, 3'd1, 1'b1, pat(m_idx), 1'b1);
        step(1'b0, 3'd0, 1'b1, 16'hFF00, 1'b1);
        idle(2);
        chk("wrap_beats", beats_checked, 257);
        chk("wrap_error", error, 0);
        chk("wrap_outstanding", outstanding, 0);

        // outstanding saturates
        for (int i = 0; i < 37; i++) step(1'b1, 3'd7, 1'b0, '0, 1'b0);
        chk("sat_outstanding", outstanding, 255);
        do_clear();

        // asynchronous reset in the middle of a burst
        step(1'b1, 3'd4, 1'b0, '0, 1'b0);
        step(1'b0, 3'd0, 1'b1, pat(m_idx), 1'b1);
        step(1'b0, 3'd0, 1'b1, pat(m_idx), 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_beats", beats_checked, 0);
        chk("arst_outstanding", outstanding, 0);
        chk("arst_error", error, 0);
        chk("arst_state", dut.r_state, S_IDLE);
        sb_q.delete();
        m_idx = 8'd0;
        prev_bc = 32'd0;
        @(negedge clk);
        reset_n = 1'b1;
        idle(1);
        step(1'b1, 3'd2, 1'b0, '0, 1'b0);
        step(1'b0, 3'd0, 1'b1, 16'hFF00, 1'b1);
        step(1'b0, 3'd0, 1'b1, 16'hFE01, 1'b1);
        idle(2);
        chk("post_rst_beats", beats_checked, 2);
        chk("post_rst_error", error, 0);
        chk("post_rst_outstanding", outstanding, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
